// File: rtl/regfile_wb_if.sv
// Bundles the write-back scheduler's bus signals.
//   issue_*  : long-latency issue marking a destination as pending
//   alu_*    : single-cycle ALU result request
//   lsu_*    : long-latency (LSU/MDU) result request
//   rs1/rs2  : operand indices under decode, with their busy flags
//   rf_*     : registered register-file write port
// The slave modport is the scheduler; the master modport is the pipeline side.
interface regfile_wb_if #(
   parameter int XLEN = 32
);
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic            issue_ready;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            lsu_valid;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_ready;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;

   modport slave (
      input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
             lsu_valid, lsu_rd, lsu_data, rs1, rs2,
      output issue_ready, alu_ready, lsu_ready, rs1_busy, rs2_busy,
             rf_we, rf_waddr, rf_wdata
   );

   modport master (
      output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
             lsu_valid, lsu_rd, lsu_data, rs1, rs2,
      input  issue_ready, alu_ready, lsu_ready, rs1_busy, rs2_busy,
             rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: shares the single register-file write port between
// the ALU and the long-latency LSU/MDU path. Tracks pending long-latency
// destinations, reports operand busy flags, and holds ALU writes behind a
// pending destination so writes to one register land in program order.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   wb    : regfile_wb_if.slave (issue/alu/lsu requests, busy flags, rf write)
module regfile_wb_scheduler #(
   parameter int NUM_REGS     = 32,
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic         clk,
   input logic         reset,
   regfile_wb_if.slave wb
);
   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [NUM_REGS-1:0] pending_reg, pending_next;
   logic [NUM_REGS-1:0] clr_vec, set_vec;
   logic [SW-1:0]       starve_reg, starve_next;
   logic                we_reg, we_next;
   logic [4:0]          waddr_reg, waddr_next;
   logic [XLEN-1:0]     wdata_reg, wdata_next;

   // Pending view widened to the full 5-bit index space; indices beyond
   // NUM_REGS read as never pending.
   logic [31:0]         pending_ext;

   logic issue_ready_c, issue_fire;
   logic alu_elig, alu_win, lsu_win;

   function automatic logic writable(input logic [4:0] rd);
      return (rd != 5'd0) && (32'(rd) < 32'(NUM_REGS));
   endfunction

   genvar gi;
   for (gi = 0; gi < 32; gi++) begin : g_ext
      if (gi < NUM_REGS) begin : g_live
         assign pending_ext[gi] = pending_reg[gi];
      end else begin : g_dead
         assign pending_ext[gi] = 1'b0;
      end
   end

   for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      assign clr_vec[gi] = lsu_win && (wb.lsu_rd == 5'(gi));
      if (gi == 0) begin : g_zero
         assign set_vec[gi] = 1'b0;
      end else begin : g_mark
         assign set_vec[gi] = issue_fire && (wb.issue_rd == 5'(gi));
      end
   end

   // A clear from an LSU grant is only visible next cycle, so an issue to
   // the same register sees it still pending and is refused this cycle.
   assign issue_ready_c = !pending_ext[wb.issue_rd];
   assign issue_fire    = wb.issue_valid && issue_ready_c;

   // ALU stalls behind a pending destination to keep WAW order.
   assign alu_elig = wb.alu_valid && !(pending_ext[wb.alu_rd] && (wb.alu_rd != 5'd0));
   assign alu_win  = alu_elig && (!wb.lsu_valid || (starve_reg == STARVE_MAX));
   assign lsu_win  = wb.lsu_valid && !alu_win;

   // New marks are ORed in after clears so an issue always leaves its
   // destination pending.
   assign pending_next = (pending_reg & ~clr_vec) | set_vec;

   always_comb begin
      starve_next = '0;
      if (alu_elig && !alu_win) begin
         starve_next = (starve_reg == STARVE_MAX) ? starve_reg : starve_reg + 1'b1;
      end
   end

   always_comb begin
      we_next    = 1'b0;
      waddr_next = waddr_reg;
      wdata_next = wdata_reg;
      if (alu_win) begin
         we_next    = writable(wb.alu_rd);
         waddr_next = wb.alu_rd;
         wdata_next = wb.alu_data;
      end else if (lsu_win) begin
         we_next    = writable(wb.lsu_rd);
         waddr_next = wb.lsu_rd;
         wdata_next = wb.lsu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_reg <= '0;
         starve_reg  <= '0;
         we_reg      <= 1'b0;
         waddr_reg   <= '0;
         wdata_reg   <= '0;
      end else begin
         pending_reg <= pending_next;
         starve_reg  <= starve_next;
         we_reg      <= we_next;
         waddr_reg   <= waddr_next;
         wdata_reg   <= wdata_next;
      end
   end

   assign wb.issue_ready = issue_ready_c;
   assign wb.alu_ready   = alu_win;
   assign wb.lsu_ready   = lsu_win;
   assign wb.rf_we       = we_reg;
   assign wb.rf_waddr    = waddr_reg;
   assign wb.rf_wdata    = wdata_reg;

   // Busy also covers the cycle where the write is still in the output register.
   assign wb.rs1_busy = (wb.rs1 != 5'd0) &&
                        (pending_ext[wb.rs1] || (we_reg && (waddr_reg == wb.rs1)));
   assign wb.rs2_busy = (wb.rs2 != 5'd0) &&
                        (pending_ext[wb.rs2] || (we_reg && (waddr_reg == wb.rs2)));
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed scenarios plus a randomized
// run checked against a behavioural model of the scheduling rules.
module tb_regfile_wb_scheduler;
   localparam int NUM_REGS     = 32;
   localparam int XLEN         = 32;
   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_wb_if #(.XLEN(XLEN)) wb ();

   regfile_wb_scheduler #(
      .NUM_REGS(NUM_REGS), .XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset), .wb(wb)
   );

   int passed = 0;
   int total  = 0;

   // Behavioural model state
   bit              m_pend [32];
   int              m_losses;
   bit              m_we;
   int              m_waddr;
   logic [XLEN-1:0] m_wdata;

   // Model view of combinational outputs for the current inputs.
   bit e_issue_ready, e_alu_ready, e_lsu_ready, e_rs1_busy, e_rs2_busy;

   function automatic bit model_busy(input int rs);
      return (rs != 0) && (m_pend[rs] || (m_we && (m_waddr == rs)));
   endfunction

   function automatic bit can_write(input int rd);
      return (rd != 0) && (rd < NUM_REGS);
   endfunction

   task automatic model_eval();
      bit elig;
      e_issue_ready = !m_pend[int'(wb.issue_rd)];
      elig = wb.alu_valid && !(wb.alu_rd != 0 && m_pend[int'(wb.alu_rd)]);
      e_alu_ready = elig && (!wb.lsu_valid || m_losses == STARVE_LIMIT);
      e_lsu_ready = wb.lsu_valid && !e_alu_ready;
      e_rs1_busy  = model_busy(int'(wb.rs1));
      e_rs2_busy  = model_busy(int'(wb.rs2));
   endtask

   // Advance one clock and apply the scheduling rules to the model.
   task automatic tick();
      bit elig;
      @(posedge clk);
      model_eval();
      elig = wb.alu_valid && !(wb.alu_rd != 0 && m_pend[int'(wb.alu_rd)]);
      if (reset) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_losses = 0;
         m_we = 1'b0; m_waddr = 0; m_wdata = '0;
      end else begin
         m_we = 1'b0;
         if (e_alu_ready) begin
            m_we = can_write(int'(wb.alu_rd)); m_waddr = int'(wb.alu_rd); m_wdata = wb.alu_data;
         end else if (e_lsu_ready) begin
            m_we = can_write(int'(wb.lsu_rd)); m_waddr = int'(wb.lsu_rd); m_wdata = wb.lsu_data;
            m_pend[int'(wb.lsu_rd)] = 1'b0;
         end
         if (wb.issue_valid && e_issue_ready && can_write(int'(wb.issue_rd)))
            m_pend[int'(wb.issue_rd)] = 1'b1;
         if (elig && !e_alu_ready) m_losses = (m_losses < STARVE_LIMIT) ? m_losses + 1 : m_losses;
         else                      m_losses = 0;
      end
      #1;
   endtask

   task automatic idle();
      wb.issue_valid = 0; wb.issue_rd = 0;
      wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = '0;
      wb.lsu_valid = 0; wb.lsu_rd = 0; wb.lsu_data = '0;
      wb.rs1 = 0; wb.rs2 = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      wb.issue_valid = 1; wb.issue_rd = 9;
      wb.alu_valid = 1; wb.alu_rd = 4; wb.alu_data = 32'h1234;
      wb.lsu_valid = 1; wb.lsu_rd = 6; wb.lsu_data = 32'h5678;
      tick();
      tick();
      reset = 0;
      idle();
      wb.rs1 = 9; wb.rs2 = 6;
      #1;
      total++; if (wb.rf_we !== 1'b0) $display("FAIL reset_we got=%b want=0", wb.rf_we); else passed++;
      total++; if (wb.rf_waddr !== 5'd0) $display("FAIL reset_waddr got=%0d want=0", wb.rf_waddr); else passed++;
      total++; if (wb.rf_wdata !== 32'd0) $display("FAIL reset_wdata got=%h want=0", wb.rf_wdata); else passed++;
      total++; if ({wb.rs1_busy, wb.rs2_busy} !== 2'b00) $display("FAIL reset_busy got=%b want=00", {wb.rs1_busy, wb.rs2_busy}); else passed++;
      total++; if (wb.issue_ready !== 1'b1) $display("FAIL reset_issue_ready got=%b want=1", wb.issue_ready); else passed++;
      $display("reset: rf_we=%b waddr=%0d wdata=%h", wb.rf_we, wb.rf_waddr, wb.rf_wdata);
   endtask

   task automatic test_issue_lsu();
      idle(); wb.issue_valid = 1; wb.issue_rd = 5; #1;
      total++; if (wb.issue_ready !== 1'b1) $display("FAIL issue5_ready got=%b want=1", wb.issue_ready); else passed++;
      tick();
      idle(); wb.rs1 = 5; #1;
      total++; if (wb.rs1_busy !== 1'b1) $display("FAIL issue5_busy got=%b want=1", wb.rs1_busy); else passed++;
      wb.lsu_valid = 1; wb.lsu_rd = 5; wb.lsu_data = 32'hDEADBEEF; #1;
      total++; if (wb.lsu_ready !== 1'b1) $display("FAIL lsu5_ready got=%b want=1", wb.lsu_ready); else passed++;
      tick();
      idle(); wb.rs1 = 5; #1;
      total++; if ({wb.rf_we, wb.rf_waddr, wb.rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
         $display("FAIL lsu5_write got=%b/%0d/%h want=1/5/deadbeef", wb.rf_we, wb.rf_waddr, wb.rf_wdata); else passed++;
      total++; if (wb.rs1_busy !== 1'b1) $display("FAIL lsu5_inflight_busy got=%b want=1", wb.rs1_busy); else passed++;
      tick();
      total++; if (wb.rs1_busy !== 1'b0) $display("FAIL lsu5_done_busy got=%b want=0", wb.rs1_busy); else passed++;
      $display("issue_lsu: x5 written deadbeef");
   endtask

   task automatic test_waw();
      idle(); wb.issue_valid = 1; wb.issue_rd = 7; tick();
      idle(); wb.alu_valid = 1; wb.alu_rd = 7; wb.alu_data = 32'h11;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (wb.alu_ready !== 1'b0) $display("FAIL waw_alu_blocked cyc=%0d got=%b want=0", i, wb.alu_ready); else passed++;
         tick();
      end
      wb.lsu_valid = 1; wb.lsu_rd = 7; wb.lsu_data = 32'h77; #1;
      total++; if ({wb.lsu_ready, wb.alu_ready} !== 2'b10) $display("FAIL waw_lsu_grant got=%b want=10", {wb.lsu_ready, wb.alu_ready}); else passed++;
      tick();
      wb.lsu_valid = 0; #1;
      total++; if ({wb.rf_we, wb.rf_waddr, wb.rf_wdata} !== {1'b1, 5'd7, 32'h77})
         $display("FAIL waw_first_write got=%b/%0d/%h want=1/7/77", wb.rf_we, wb.rf_waddr, wb.rf_wdata); else passed++;
      total++; if (wb.alu_ready !== 1'b1) $display("FAIL waw_alu_release got=%b want=1", wb.alu_ready); else passed++;
      tick();
      idle(); #1;
      total++; if ({wb.rf_we, wb.rf_waddr, wb.rf_wdata} !== {1'b1, 5'd7, 32'h11})
         $display("FAIL waw_second_write got=%b/%0d/%h want=1/7/11", wb.rf_we, wb.rf_waddr, wb.rf_wdata); else passed++;
      tick();
      $display("waw: x7 order lsu(77) then alu(11)");
   endtask

   task automatic test_arbitration();
      idle(); tick();
      wb.alu_valid = 1; wb.alu_rd = 10; wb.alu_data = 32'hA;
      wb.lsu_valid = 1; wb.lsu_rd = 11; wb.lsu_data = 32'hB;
      for (int k = 0; k < 15; k++) begin
         bit want_alu;
         want_alu = ((k % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
         #1;
         total++; if ({wb.alu_ready, wb.lsu_ready} !== {want_alu, !want_alu})
            $display("FAIL arb cyc=%0d got alu/lsu=%b%b want=%b%b", k, wb.alu_ready, wb.lsu_ready, want_alu, !want_alu);
         else passed++;
         tick();
      end
      idle(); tick();
      $display("arbitration: 15 cycles of contention");
   endtask

   task automatic test_x0();
      idle(); wb.alu_valid = 1; wb.alu_rd = 0; wb.alu_data = 32'hFFFFFFFF; #1;
      total++; if (wb.alu_ready !== 1'b1) $display("FAIL x0_alu_ack got=%b want=1", wb.alu_ready); else passed++;
      tick();
      idle(); wb.issue_valid = 1; wb.issue_rd = 0; #1;
      total++; if (wb.rf_we !== 1'b0) $display("FAIL x0_no_write got=%b want=0", wb.rf_we); else passed++;
      total++; if (wb.issue_ready !== 1'b1) $display("FAIL x0_issue_ready got=%b want=1", wb.issue_ready); else passed++;
      tick();
      idle(); #1;
      total++; if ({wb.rs1_busy, wb.rs2_busy} !== 2'b00) $display("FAIL x0_busy got=%b want=00", {wb.rs1_busy, wb.rs2_busy}); else passed++;
      $display("x0: write dropped, issue accepted");
   endtask

   task automatic test_collision();
      idle(); wb.issue_valid = 1; wb.issue_rd = 3; tick();
      wb.lsu_valid = 1; wb.lsu_rd = 3; wb.lsu_data = 32'h33; #1;
      total++; if ({wb.lsu_ready, wb.issue_ready} !== 2'b10) $display("FAIL coll_same_cycle got lsu/issue=%b want=10", {wb.lsu_ready, wb.issue_ready}); else passed++;
      tick();
      wb.lsu_valid = 0; #1;
      total++; if (wb.issue_ready !== 1'b1) $display("FAIL coll_next_ready got=%b want=1", wb.issue_ready); else passed++;
      tick();
      idle(); wb.rs1 = 3; tick(); #1;
      total++; if (wb.rs1_busy !== 1'b1) $display("FAIL coll_pending got=%b want=1", wb.rs1_busy); else passed++;
      wb.lsu_valid = 1; wb.lsu_rd = 3; wb.lsu_data = 32'h34; tick();
      idle(); tick();
      $display("collision: x3 reissued after clear");
   endtask

   task automatic test_random();
      int errs = 0;
      for (int n = 0; n < 400; n++) begin
         wb.issue_valid = 1'($urandom_range(0, 1));
         wb.issue_rd    = 5'($urandom_range(0, 7));
         wb.alu_valid   = 1'($urandom_range(0, 1));
         wb.alu_rd      = 5'($urandom_range(0, 7));
         wb.alu_data    = $urandom;
         wb.lsu_valid   = ($urandom_range(0, 3) != 0);
         wb.lsu_rd      = 5'($urandom_range(0, 7));
         wb.lsu_data    = $urandom;
         wb.rs1         = 5'($urandom_range(0, 7));
         wb.rs2         = 5'($urandom_range(0, 31));
         if (wb.issue_valid && wb.lsu_valid && wb.issue_rd == wb.lsu_rd) wb.issue_valid = 0;
         #1;
         model_eval();
         total++;
         if ({wb.issue_ready, wb.alu_ready, wb.lsu_ready, wb.rs1_busy, wb.rs2_busy} !==
             {e_issue_ready, e_alu_ready, e_lsu_ready, e_rs1_busy, e_rs2_busy}) begin
            errs++;
            $display("FAIL rand_comb n=%0d got=%b want=%b", n,
               {wb.issue_ready, wb.alu_ready, wb.lsu_ready, wb.rs1_busy, wb.rs2_busy},
               {e_issue_ready, e_alu_ready, e_lsu_ready, e_rs1_busy, e_rs2_busy});
         end else passed++;
         tick();
         total++;
         if (wb.rf_we !== m_we || (m_we && (int'(wb.rf_waddr) != m_waddr || wb.rf_wdata !== m_wdata))) begin
            errs++;
            $display("FAIL rand_write n=%0d got=%b/%0d/%h want=%b/%0d/%h", n,
               wb.rf_we, wb.rf_waddr, wb.rf_wdata, m_we, m_waddr, m_wdata);
         end else passed++;
      end
      $display("random: 400 cycles, %0d discrepancies", errs);
   endtask

   initial begin
      idle();
      reset = 1;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_losses = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
      test_reset();
      test_issue_lsu();
      test_waw();
      test_arbitration();
      test_x0();
      test_collision();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the core register file: shares its single write port between the single-cycle ALU path and the long-latency LSU/MDU path. Keeps a per-register pending scoreboard for long-latency destinations, exposes busy flags for operand hazard stalls, and enforces write-after-write ordering. Sits between the execute/memory stages and the register file write port, with the register file write inputs driven from its registered outputs.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count (16 for RV32E builds); rd >= NUM_REGS is never written
- XLEN, 32, data width
- STARVE_LIMIT, 4, consecutive ALU arbitration losses before the ALU is forced a grant

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  long-latency op issued; mark issue_rd pending
- issue_rd  in  5  destination of the issued op
- issue_ready  out  1  issue accepted this cycle
- alu_valid  in  1  ALU result available
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result consumed this cycle
- lsu_valid  in  1  long-latency result available
- lsu_rd  in  5  long-latency destination
- lsu_data  in  XLEN  long-latency result
- lsu_ready  out  1  long-latency result consumed this cycle
- rs1, rs2  in  5 each  operand indices being decoded
- rs1_busy, rs2_busy  out  1 each  operand not yet safe to read
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  XLEN  register file write data (registered)

## Operation
- State: pending[NUM_REGS-1:0]; starve counter (width clog2(STARVE_LIMIT+1)); rf_we/rf_waddr/rf_wdata output registers.
- Reset: pending all 0, starve counter 0, rf_we 0, rf_waddr 0, rf_wdata 0. Reset mid-operation discards all pending marks and any in-flight write; rf_we is 0 in the cycle after reset is sampled.
- Issue: issue_ready = !pending[issue_rd]. On issue_valid && issue_ready, set pending[issue_rd] unless issue_rd == 0 or issue_rd >= NUM_REGS (accepted, no mark).
- ALU eligible: alu_valid && !(pending[alu_rd] && alu_rd != 0). Blocking on a pending rd enforces WAW ordering.
- Arbitration, one grant per cycle:
  - Default priority goes to the LSU.
  - The ALU wins if it is eligible and either lsu_valid = 0 or starve counter == STARVE_LIMIT.
  - lsu_ready = lsu_valid && !alu_win.
  - alu_ready = alu_win.
- Starve counter:
  - Increments (saturating) when the ALU is eligible but loses.
  - Clears on an ALU grant or when the ALU is not eligible.
- Granted write:
  - Next cycle rf_we = 1 and rf_waddr/rf_wdata = winner rd/data.
  - If rd == 0 or rd >= NUM_REGS, rf_we = 0; the request is still acknowledged.
  - An LSU grant clears pending[lsu_rd].
  - An LSU write to a non-pending rd is legal and writes normally.
- Same-cycle events:
  - An LSU grant clearing rd together with an issue to the same rd: issue_ready = 0 that cycle, because the clear is not visible until the next cycle.
  - A clear and a set on different rds apply together.
- Busy flags: rsN_busy = rsN != 0 && (pending[rsN] || (rf_we && rf_waddr == rsN)). This covers the cycle in which the register file write is still in flight.

## Timing
- Grant to rf_we: 1 cycle. ready signals are combinational from the current inputs and state.
- issue_ready, alu_ready, lsu_ready and rsN_busy are combinational. pending and the outputs update on the clock edge.
- Throughput: one register write per cycle.
- Worst-case ALU wait with continuous LSU traffic: STARVE_LIMIT cycles, then one forced ALU grant.

## Test plan
- Reset: assert reset with issue and both requesters active. Next cycle: rf_we = 0, rf_waddr = 0, rf_wdata = 0, all busy flags 0, issue_ready = 1.
- Issue x5, then query rs1 = 5: rs1_busy = 1. LSU writes x5 = 0xDEADBEEF, lsu_ready = 1. Next cycle: rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF, rs1_busy still 1. One cycle later rs1_busy = 0.
- WAW: x7 pending, ALU requests x7 = 0x11. alu_ready stays 0 until the LSU writes x7. The ALU write follows, so the final write order is LSU then ALU.
- Arbitration: LSU and ALU valid every cycle (ALU rd not pending), STARVE_LIMIT = 4. Four LSU grants, then one ALU grant, repeating.
- x0 handling: ALU write to x0 = 0xFFFFFFFF is acknowledged with rf_we = 0. Issue to x0 is accepted and rs1 = 0 is never busy.
- Collision: LSU grant on x3 in the same cycle as an issue to x3. issue_ready = 0; the issue is accepted the next cycle and pending[3] = 1 afterwards.
